// File: rtl/serial_word_deserializer_pkg.sv
// Shared types for the serial word deserializer.
// State encoding and shift-direction constants.
package serial_word_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_deserializer_out_stage.sv
// deser_out_stage: valid/ready holding register with drop detect.
// in: word, perr, deliver, out_ready; out: out_data/valid/perr, drop.
module deser_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] word,
  input  logic             perr,
  input  logic             deliver,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_perr,
  output logic             drop
);

  logic room;

  assign room = !out_valid || out_ready;
  assign drop = deliver && !room;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
    end else if (deliver && room) begin
      out_data  <= word;
      out_valid <= 1'b1;
      out_perr  <= perr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel receiver, MSB- or LSB-first, valid/ready output.
// Ports: clk, rstn, sdi/sdi_en/frame/dir in; out_* stage; overrun,
// sync_err sticky flags with clr_err. Parity bit after each word when
// SERIAL_WORD_DESERIALIZER_PARITY_EN is defined.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sdi,
  input  logic             sdi_en,
  input  logic             frame,
  input  logic             dir,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic             overrun,
  output logic             sync_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sh, first, word;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dir_q, dir_n;
  logic             deliver, perr, sync_set, drop;

  always_comb begin
    sh = (dir_q == DIR_LSB_FIRST) ? {sdi, sr[WIDTH-1:1]}
                                  : {sr[WIDTH-2:0], sdi};
    // a frame bit starts from an empty register
    first = '0;
    if (dir == DIR_LSB_FIRST) first[WIDTH-1] = sdi;
    else                      first[0]       = sdi;
  end

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    dir_n    = dir_q;
    deliver  = 1'b0;
    perr     = 1'b0;
    sync_set = 1'b0;
    if (sdi_en) begin
      if (frame) begin
        sync_set = (state != IDLE);
        sr_n     = first;
        cnt_n    = CW'(1);
        dir_n    = dir;
        state_n  = SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            sr_n  = sh;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
              state_n = PARITY;
`else
              deliver = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
`endif
            end
          end
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
          PARITY: begin
            deliver = 1'b1;
            perr    = ^{sr, sdi};
            cnt_n   = '0;
            state_n = IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
  assign word = sr;
`else
  assign word = sh;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      dir_q    <= DIR_MSB_FIRST;
      overrun  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      cnt      <= cnt_n;
      dir_q    <= dir_n;
      // a set on the same edge beats clr_err
      overrun  <= drop || (overrun && !clr_err);
      sync_err <= sync_set || (sync_err && !clr_err);
    end
  end

  deser_out_stage #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk      (clk),
    .rstn     (rstn),
    .word     (word),
    .perr     (perr),
    .deliver  (deliver),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_perr (out_perr),
    .drop     (drop)
  );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer (WIDTH=8).
// Adapts to SERIAL_WORD_DESERIALIZER_PARITY_EN.
module tb_serial_word_deserializer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sdi = 1'b0;
  logic       sdi_en = 1'b0;
  logic       frame = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_perr;
  logic       overrun;
  logic       sync_err;
  logic       clr_err = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_word_deserializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sdi      (sdi),
    .sdi_en   (sdi_en),
    .frame    (frame),
    .dir      (dir),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_perr (out_perr),
    .overrun  (overrun),
    .sync_err (sync_err),
    .clr_err  (clr_err)
  );

  task automatic send_bit(input logic b, input logic f, input logic d);
    @(negedge clk);
    sdi = b; frame = f; dir = d; sdi_en = 1'b1;
    @(posedge clk);
    #1;
    sdi_en = 1'b0; frame = 1'b0;
  endtask

  // seq[7] goes on the wire first; parity bit follows in parity build
  task automatic send_seq(input logic [7:0] seq, input logic d,
                          input logic par);
    for (int i = 7; i >= 0; i--)
      send_bit(seq[i], i == 7, d);
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    send_bit(par, 1'b0, d);
`else
    if (par) $display("note: parity bit ignored in this build");
`endif
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h want 0/00",
               out_valid, out_data);
    end
    checks++;
    if ({overrun, sync_err, out_perr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ovr/sync/perr=%b want 000",
               {overrun, sync_err, out_perr});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_msb_first();
    out_ready = 1'b1;
    send_seq(8'b1011_0010, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_perr !== 1'b0) begin
      errors++;
      $display("FAIL msb_word: valid=%b data=%h perr=%b want 1/b2/0",
               out_valid, out_data, out_perr);
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL msb_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_lsb_first();
    send_seq(8'b1011_0010, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h4D) begin
      errors++;
      $display("FAIL lsb_word: valid=%b data=%h want 1/4d",
               out_valid, out_data);
    end
    idle_cycle();
  endtask

  task automatic test_gap();
    for (int i = 0; i < 4; i++)
      send_bit(1'b0, i == 0, 1'b0);
    repeat (3) idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_mid: valid=%b want 0", out_valid);
    end
    // dir toggled mid-word must be ignored
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    send_bit(1'b1, 1'b0, 1'b0);
`endif
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0D) begin
      errors++;
      $display("FAIL gap_word: valid=%b data=%h want 1/0d",
               out_valid, out_data);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    send_seq(8'hB2, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2) begin
      errors++;
      $display("FAIL b2b_first: valid=%b data=%h want 1/b2",
               out_valid, out_data);
    end
    send_seq(8'h0F, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0F || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h ovr=%b want 1/0f/0",
               out_valid, out_data, overrun);
    end
    idle_cycle();
  endtask

  task automatic test_overrun();
    @(negedge clk);
    out_ready = 1'b0;
    send_seq(8'hB2, 1'b0, 1'b0);
    send_seq(8'h0F, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: valid=%b data=%h ovr=%b want 1/b2/1",
               out_valid, out_data, overrun);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0 || out_data !== 8'hB2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_clr: ovr=%b data=%h valid=%b want 0/b2/1",
               overrun, out_data, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sync();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_seq(8'hA5, 1'b0, 1'b0);
    checks++;
    if (sync_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL sync_word: sync=%b valid=%b data=%h want 1/1/a5",
               sync_err, out_valid, out_data);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    checks++;
    if (sync_err !== 1'b0) begin
      errors++;
      $display("FAIL sync_clr: sync=%b want 0", sync_err);
    end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++)
      send_bit(1'b1, i == 0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: valid=%b ovr=%b sync=%b want 000",
               out_valid, overrun, sync_err);
    end
    send_seq(8'h3C, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C ||
        overrun !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_word: valid=%b data=%h ovr=%b sync=%b want 1/3c/0/0",
               out_valid, out_data, overrun, sync_err);
    end
    idle_cycle();
  endtask

  task automatic test_parity();
`ifdef SERIAL_WORD_DESERIALIZER_PARITY_EN
    send_seq(8'hB2, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_perr !== 1'b0) begin
      errors++;
      $display("FAIL par_good: valid=%b data=%h perr=%b want 1/b2/0",
               out_valid, out_data, out_perr);
    end
    send_seq(8'hB2, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_perr !== 1'b1) begin
      errors++;
      $display("FAIL par_bad: valid=%b data=%h perr=%b want 1/b2/1",
               out_valid, out_data, out_perr);
    end
`else
    send_seq(8'h01, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01 || out_perr !== 1'b0) begin
      errors++;
      $display("FAIL perr_tied: valid=%b data=%h perr=%b want 1/01/0",
               out_valid, out_data, out_perr);
    end
`endif
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gap();
    test_back_to_back();
    test_overrun();
    test_sync();
    test_reset_midword();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
